// File: rtl/game_pkg.sv
// Shared runner-game types and constants used by the sequencer and the drawers.
// Pure declarations: no logic, no latency, no backpressure.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_e;

  localparam int COORD_W = 12;
  localparam int SPEED_W = 4;
  localparam int SCORE_W = 17;

  // One bit wider than a coordinate so it can be compared against a 13-bit sum.
  localparam logic [COORD_W:0]   HORIZON_W = 13'd2400;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 17'd99999;

endpackage

// File: rtl/scroll_ctrl_if.sv
// Sequencer I/O bundle: key/collision in from the game, motion state out to the drawers.
// Plain per-frame levels, no handshake; master = game side, slave = scroll_ctrl.
interface scroll_ctrl_if;
  import game_pkg::*;

  logic               start_key;
  logic               collide;
  state_e             state;
  logic               dead;
  logic [COORD_W-1:0] scroll_x;
  logic [COORD_W-1:0] cloud_x;
  logic [SPEED_W-1:0] step;
  logic [SPEED_W-1:0] speed;
  logic [SCORE_W-1:0] score;

  modport master (
    output start_key, collide,
    input  state, dead, scroll_x, cloud_x, step, speed, score
  );

  modport slave (
    input  start_key, collide,
    output state, dead, scroll_x, cloud_x, step, speed, score
  );

endinterface

// File: rtl/scroll_ctrl_wrap_accum.sv
// Registered modulo-HORIZON_W accumulator; updates one frame after i_en.
// No backpressure: holds its value whenever i_en is low.
module wrap_accum
  import game_pkg::*;
(
  input  logic               frame_Clk,
  input  logic               Reset,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_inc,
  output logic [COORD_W-1:0] o_val
);

  logic [COORD_W-1:0] r_val;
  logic [COORD_W:0]   w_sum;
  logic [COORD_W-1:0] w_wrapped;

  // Increment is always below HORIZON_W, so one conditional subtract wraps fully.
  assign w_sum     = {1'b0, r_val} + {1'b0, i_inc};
  assign w_wrapped = (w_sum >= HORIZON_W) ? COORD_W'(w_sum - HORIZON_W) : COORD_W'(w_sum);

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset)     r_val <= '0;
    else if (i_en) r_val <= w_wrapped;
  end

  assign o_val = r_val;

endmodule

// File: rtl/scroll_ctrl.sv
// Runner-game frame sequencer: IDLE/RUN/DEAD FSM, speed ramp, score and scroll offsets.
// All outputs registered, one frame after the sampled inputs; no backpressure.
module scroll_ctrl
  import game_pkg::*;
#(
  parameter int SPEED_INIT   = 4,
  parameter int SPEED_MAX    = 12,
  parameter int RAMP_FRAMES  = 600,
  parameter int SCORE_DIV    = 6,
  parameter int DEAD_LOCKOUT = 30
) (
  input  logic         frame_Clk,
  input  logic         Reset,
  scroll_ctrl_if.slave bus
);

  localparam int RAMP_W = $clog2(RAMP_FRAMES);
  localparam int DIV_W  = $clog2(SCORE_DIV);
  localparam int LOCK_W = $clog2(DEAD_LOCKOUT + 1);

  localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(DEAD_LOCKOUT);

  state_e             r_state, w_next_state;
  logic               r_start_q, r_dead;
  logic [SPEED_W-1:0] r_speed, r_step, w_speed_next;
  logic [SCORE_W-1:0] r_score;
  logic [RAMP_W-1:0]  r_ramp_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic               w_start_edge, w_run_adv, w_collide_hit, w_restart;
  logic [COORD_W-1:0] w_scroll_inc, w_cloud_inc, w_scroll_x, w_cloud_x;

  assign w_start_edge = bus.start_key & ~r_start_q;

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_edge)                      w_next_state = RUN;
      RUN:     if (bus.collide)                       w_next_state = DEAD;
      DEAD:    if (w_start_edge && r_lock_cnt == '0)  w_next_state = RUN;
      default:                                        w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_run_adv     = 1'b0;
    w_collide_hit = 1'b0;
    w_restart     = 1'b0;
    case (r_state)
      RUN: begin
        w_run_adv     = ~bus.collide;
        w_collide_hit = bus.collide;
      end
      DEAD:    w_restart = (w_next_state == RUN);
      default: ;
    endcase
  end

  always_comb begin
    w_speed_next = r_speed;
    if (w_restart)
      w_speed_next = SPD_INIT;
    else if (w_run_adv && r_ramp_cnt == RAMP_LAST && r_speed < SPD_MAX)
      w_speed_next = r_speed + 1'b1;
  end

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      r_start_q  <= 1'b0;
      r_speed    <= SPD_INIT;
      r_step     <= '0;
      r_dead     <= 1'b0;
      r_score    <= '0;
      r_ramp_cnt <= '0;
      r_div_cnt  <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_start_q <= bus.start_key;
      r_speed   <= w_speed_next;
      // step mirrors the speed the scroll will use next frame, zero outside RUN
      r_step    <= (w_next_state == RUN) ? w_speed_next : '0;
      r_dead    <= (w_next_state == DEAD);
      if (w_restart) begin
        r_score    <= '0;
        r_ramp_cnt <= '0;
        r_div_cnt  <= '0;
      end else if (w_run_adv) begin
        r_ramp_cnt <= (r_ramp_cnt == RAMP_LAST) ? '0 : r_ramp_cnt + 1'b1;
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt <= '0;
          if (r_score < SCORE_MAX) r_score <= r_score + 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
      if (w_collide_hit)
        r_lock_cnt <= LOCK_LOAD;
      else if (r_state == DEAD && r_lock_cnt != '0)
        r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  assign w_scroll_inc = COORD_W'(r_speed);
  assign w_cloud_inc  = COORD_W'(r_speed >> 1);

  wrap_accum u_scroll (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .i_en      (w_run_adv),
    .i_inc     (w_scroll_inc),
    .o_val     (w_scroll_x)
  );

  wrap_accum u_cloud (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .i_en      (w_run_adv),
    .i_inc     (w_cloud_inc),
    .o_val     (w_cloud_x)
  );

  assign bus.state    = r_state;
  assign bus.dead     = r_dead;
  assign bus.scroll_x = w_scroll_x;
  assign bus.cloud_x  = w_cloud_x;
  assign bus.step     = r_step;
  assign bus.speed    = r_speed;
  assign bus.score    = r_score;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboarded random/directed bench for scroll_ctrl against a frame-level reference model.
// Stimulus pushes expected outputs per frame; a monitor pops and compares after each edge.
module tb_scroll_ctrl;
  import game_pkg::*;

  logic frame_Clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_Clk = ~frame_Clk;

  scroll_ctrl_if bus ();

  scroll_ctrl dut (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  typedef struct {
    int state;
    int dead;
    int scroll;
    int cloud;
    int step;
    int speed;
    int score;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: speed and score derived from RUN frames since (re)start.
  int m_state, m_scroll, m_cloud, m_speed, m_score, m_run, m_dead_frames, m_prev;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    m_state = 0; m_scroll = 0; m_cloud = 0; m_speed = 4; m_score = 0;
    m_run = 0; m_dead_frames = 0; m_prev = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sk, input int col);
    exp_t e;
    int   edge_s;
    bus.start_key = sk[0];
    bus.collide   = col[0];
    edge_s = (sk != 0 && m_prev == 0) ? 1 : 0;
    m_prev = sk;
    case (m_state)
      0: if (edge_s != 0) m_state = 1;
      1: begin
        if (col != 0) begin
          m_state = 2;
          m_dead_frames = 0;
        end else begin
          m_scroll = (m_scroll + m_speed) % 2400;
          m_cloud  = (m_cloud + m_speed / 2) % 2400;
          m_run++;
          m_speed = imin(4 + m_run / 600, 12);
          m_score = imin(m_run / 6, 99999);
        end
      end
      default: begin
        m_dead_frames++;
        if (edge_s != 0 && m_dead_frames > 30) begin
          m_state = 1; m_run = 0; m_speed = 4; m_score = 0;
        end
      end
    endcase
    e.state = m_state; e.dead = (m_state == 2) ? 1 : 0;
    e.scroll = m_scroll; e.cloud = m_cloud;
    e.step = (m_state == 1) ? m_speed : 0;
    e.speed = m_speed; e.score = m_score;
    exp_q.push_back(e);
  endtask

  task automatic frame(input int sk, input int col);
    @(negedge frame_Clk);
    drive(sk, col);
  endtask

  task automatic settle();
    @(posedge frame_Clk);
    #3;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  32'(bus.state),    0);
    check({tag, "_dead"},   32'(bus.dead),     0);
    check({tag, "_scroll"}, 32'(bus.scroll_x), 0);
    check({tag, "_cloud"},  32'(bus.cloud_x),  0);
    check({tag, "_step"},   32'(bus.step),     0);
    check({tag, "_speed"},  32'(bus.speed),    4);
    check({tag, "_score"},  32'(bus.score),    0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge frame_Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",  32'(bus.state),    e.state);
        check("dead",   32'(bus.dead),     e.dead);
        check("scroll", 32'(bus.scroll_x), e.scroll);
        check("cloud",  32'(bus.cloud_x),  e.cloud);
        check("step",   32'(bus.step),     e.step);
        check("speed",  32'(bus.speed),    e.speed);
        check("score",  32'(bus.score),    e.score);
        check("scroll_in_range", (bus.scroll_x < 12'd2400) ? 32'd1 : 32'd0, 1);
      end
    end
  end

  initial begin : stim
    bus.start_key = 1'b0;
    bus.collide   = 1'b0;
    m_reset();
    #1 Reset = 1'b1;
    #3 check_reset_vals("rst");
    repeat (2) @(negedge frame_Clk);
    Reset = 1'b0;
    drive(0, 0);

    // Start, then ten RUN frames with the key held
    frame(0, 0);
    frame(1, 0);
    for (int i = 0; i < 10; i++) frame(1, 0);
    settle();
    check("run10_state",  32'(bus.state),    1);
    check("run10_scroll", 32'(bus.scroll_x), 40);
    check("run10_cloud",  32'(bus.cloud_x),  20);
    check("run10_score",  32'(bus.score),    1);

    // Collide and a start edge in the same frame: collide wins
    frame(0, 0);
    frame(1, 1);
    settle();
    check("coll_state",  32'(bus.state),    2);
    check("coll_scroll", 32'(bus.scroll_x), 44);
    check("coll_score",  32'(bus.score),    1);

    // Edge 10 frames after death is ignored; edge 31 frames after restarts
    for (int k = 1; k <= 31; k++) begin
      frame((k == 10 || k == 31) ? 1 : 0, 0);
      if (k == 10) begin
        settle();
        check("lockout_state", 32'(bus.state), 2);
      end
    end
    settle();
    check("restart_state",  32'(bus.state),    1);
    check("restart_score",  32'(bus.score),    0);
    check("restart_speed",  32'(bus.speed),    4);
    check("restart_scroll", 32'(bus.scroll_x), 44);

    // Speed ramp and saturation (scroll wraps many times on the way)
    for (int i = 0; i < 600; i++) frame(0, 0);
    settle();
    check("ramp_speed", 32'(bus.speed), 5);
    check("ramp_step",  32'(bus.step),  5);
    for (int i = 0; i < 4800; i++) frame(0, 0);
    settle();
    check("sat_speed", 32'(bus.speed), 12);

    // Asynchronous reset between edges, released with the key already high
    @(posedge frame_Clk);
    #3 Reset = 1'b1;
    #1 check_reset_vals("async");
    m_reset();
    bus.start_key = 1'b1;
    repeat (2) @(negedge frame_Clk);
    Reset = 1'b0;
    drive(1, 0);
    settle();
    check("key_at_release_state", 32'(bus.state), 1);

    // Random play
    for (int i = 0; i < 4000; i++)
      frame(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 39) == 0) ? 1 : 0);
    frame(0, 0);
    settle();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Frame-rate game sequencer for the runner game: owns the run/dead state machine and generates the shared scroll position, scroll speed, parallax offset and score. The horizon, obstacle and cloud drawers consume these outputs; they no longer keep their own motion state. It runs entirely in the frame_Clk domain and updates once per video frame.

## Interface
- HORIZON_W, 2400: horizon strip width in pixels; modulus for scroll_x and cloud_x.
- SPEED_INIT, 4: speed in pixels per frame at reset and at each restart.
- SPEED_MAX, 12: speed saturation value. Must be less than HORIZON_W.
- RAMP_FRAMES, 600: number of RUN frames per speed increment.
- SCORE_DIV, 6: number of RUN frames per score point.
- SCORE_MAX, 99999: score saturation value.
- DEAD_LOCKOUT, 30: number of DEAD frames during which restart is ignored.

Ports:
- frame_Clk  in  1  frame clock. All state updates on its rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- start_key  in  1  jump/start key level, already synchronous to frame_Clk.
- collide  in  1  collision flag from the sprite logic, level, valid per frame.
- state  out  2  0 = IDLE, 1 = RUN, 2 = DEAD.
- dead  out  1  1 when state is DEAD.
- scroll_x  out  12  horizon start offset in pixels, range 0..HORIZON_W-1.
- cloud_x  out  12  parallax offset, range 0..HORIZON_W-1.
- step  out  4  pixels advanced this frame: equals speed in RUN, 0 otherwise.
- speed  out  4  current speed.
- score  out  17  current score, range 0..SCORE_MAX.

## Operation
- Reset values: state = IDLE, scroll_x = 0, cloud_x = 0, speed = SPEED_INIT, step = 0, score = 0. The internal counters (ramp_cnt, div_cnt, lock_cnt) and the start_key delay register start_q are all 0.
- Start edge: start_edge = start_key & ~start_q. start_q is updated every frame.
- IDLE:
  - Nothing advances.
  - start_edge moves the block to RUN.
- RUN (one update per frame):
  - If collide is high: go to DEAD and load lock_cnt = DEAD_LOCKOUT. Nothing else advances that frame, so collide has priority over all other actions.
  - Otherwise:
    - scroll_x += speed, modulo HORIZON_W.
    - cloud_x += speed>>1, modulo HORIZON_W.
    - ramp_cnt counts up; when it reaches RAMP_FRAMES-1 it wraps to 0 and speed increments, saturating at SPEED_MAX.
    - div_cnt counts up; when it reaches SCORE_DIV-1 it wraps to 0 and score increments, saturating at SCORE_MAX.
- DEAD:
  - Nothing advances.
  - score remains readable.
  - lock_cnt decrements to 0 and then stays at 0.
  - start_edge is ignored while lock_cnt is nonzero.
  - When lock_cnt is 0 and start_edge occurs: go to RUN, set speed = SPEED_INIT, and clear score, ramp_cnt and div_cnt. scroll_x and cloud_x keep their values for visual continuity.
- Modulo arithmetic:
  - Each increment is below HORIZON_W, so a single conditional subtract is sufficient: if sum >= HORIZON_W, the result is sum - HORIZON_W.
  - Use 13-bit intermediate sums.
- A held start_key produces exactly one start_edge.
- If start_key is high when Reset releases, the first frame produces a start_edge.
- Reset asserted mid-run returns every register to its reset value immediately (asynchronously).

## Timing
- All outputs are registered.
- Any input sampled at frame edge N is reflected on the outputs after edge N.
- step and speed change in the same frame as the state transition that causes them.
- A speed increment takes effect on the scroll_x update of the following frame.
- Consumers sample the outputs during the active video of frame N+1.

## Structure
- Shared package game_pkg holds:
  - the state enum (IDLE, RUN, DEAD);
  - HORIZON_W;
  - SCORE_MAX;
  - a coordinate width constant (12).
- The drawers import these from game_pkg.
- One sub-module, wrap_accum: a registered modulo-HORIZON_W accumulator with an enable and an increment input. It is instantiated twice, once for scroll_x and once for cloud_x.
- The FSM and counters stay in the top module.

## Test plan
- Reset, then a start_key pulse: state goes to 1 the next frame. After 10 RUN frames, scroll_x = 40, cloud_x = 20, score = 1 (SCORE_DIV = 6).
- Wrap-around: force scroll_x = 2398 in RUN at speed 4. Next frame scroll_x = 2; it never reads 2400 or above.
- Ramp: run 600 frames from start. speed reads 5 after frame 600 and step = 5. Run 8 × 600 more frames: speed saturates at 12.
- Collide and start_key rising edge in the same RUN frame: state becomes DEAD and scroll_x and score are unchanged.
- Restart in DEAD:
  - a start edge 10 frames after death is ignored;
  - a start edge 31 frames after death gives RUN with score = 0 and speed = 4, and scroll_x is unchanged.
- Reset asserted mid-RUN between clock edges: all outputs return to their reset values immediately, without waiting for a frame_Clk edge.
